screen_clear_sweeper: RTL and testbench
=======================================

// Module: screen_clear_sweeper
// PURPOSE
//  Generates the clear-pass pixel stream (x, y, colour, plot) that overwrites a rectangle of the
//  160x120 VGA frame with one fixed colour: a region (erase old pipe/bird sprites) or the full screen.
//  Drives the clear inputs and the clear/regular select of the downstream VGA clear/regular mux.
//  The select holds that mux on the clear path while a sweep runs.
// PARAMETERS
//  SCREEN_W     160     frame width in pixels; x coordinates 0..SCREEN_W-1
//  SCREEN_H     120     frame height in pixels; y coordinates 0..SCREEN_H-1
//  CLEAR_COLOR  3'b000  colour written to every swept pixel (black)
// PORTS
//  clock                  in   1  system clock; all state changes on the rising edge
//  reset                  in   1  asynchronous, active-high; returns the block to IDLE
//  start                  in   1  sweep request; sampled only in IDLE
//  full_screen            in   1  sampled with start; 1 = sweep the whole frame and ignore rect_*
//  rect_x0                in   8  rectangle left column
//  rect_y0                in   7  rectangle top row
//  rect_w                 in   8  rectangle width in pixels (0 = empty)
//  rect_h                 in   7  rectangle height in pixels (0 = empty)
//  hold                   in   1  1 = freeze the sweep this cycle (shared pixel bus busy)
//  x_clear                out  8  current pixel column
//  y_clear                out  7  current pixel row
//  color_clear            out  3  current pixel colour; always CLEAR_COLOR
//  plot                   out  1  1 = x_clear/y_clear/color_clear is a valid write this cycle
//  busy                   out  1  1 while in SWEEP
//  done                   out  1  one-cycle pulse after the last pixel, or after an empty request
//  send_clear_or_regular  out  1  0 = select clear path, 1 = select regular path; equals ~busy
// BEHAVIOUR
//  Reset and output timing
//   - Reset (async): state=IDLE; x_clear=0, y_clear=0, plot=0, busy=0, done=0,
//     send_clear_or_regular=1. color_clear is constant CLEAR_COLOR.
//   - Reset asserted mid-sweep aborts the sweep immediately. No done pulse follows.
//   - All outputs are registered except color_clear (constant).
//  FSM: IDLE -> SWEEP -> DONE -> IDLE
//   - IDLE, start=1: latch the region and compute the clipped bounds.
//       x_end = min(x0+w-1, SCREEN_W-1); y_end = min(y0+h-1, SCREEN_H-1).
//       Compute in 9 bits so the sum cannot overflow.
//       The region is empty if w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H.
//       full_screen=1 forces the region to 0..SCREEN_W-1 by 0..SCREEN_H-1.
//   - Non-empty region: go to SWEEP with x_clear=x0, y_clear=y0, plot=1, busy=1 and
//     send_clear_or_regular=0. All of these are visible the cycle after start is sampled.
//   - Empty region: go to DONE directly, with no plot.
//   - SWEEP, hold=0: advance in raster order, x fastest.
//       x<x_end: x+1.  Otherwise: x=x0, y+1.
//   - SWEEP, leaving the last pixel (x_end, y_end): go to DONE with plot=0, busy=0, done=1.
//   - SWEEP, hold=1: plot=0, x/y frozen, busy stays 1. The pixel presented when hold drops
//     is the same one that was not yet advanced past; no pixel is skipped or duplicated.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//  Request handling
//   - start is ignored in SWEEP and DONE. Requests are neither queued nor restarted.
//   - start and hold asserted together in IDLE: start is accepted. hold only affects SWEEP.
//  Latency and counts
//   - N = w_eff*h_eff pixels. With no hold, the first plot is at cycle S+1, the last at S+N,
//     and done at S+N+1 (S = the cycle in which start is sampled).
//   - Each hold cycle adds exactly one cycle.
// TESTING
//  1. full_screen=1, start for 1 cycle -> 19200 plots.
//     First (0,0), last (159,119); done at S+19201; send_clear_or_regular=0 throughout.
//  2. rect (10,20,3,2) -> plots (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), then done next cycle.
//  3. rect (158,118,5,5) -> clipped to 4 plots: (158,118)(159,118)(158,119)(159,119).
//  4. rect_w=0 or rect_x0=170 -> zero plots, busy never 1, done at S+1.
//  5. hold=1 for 3 cycles while presenting (11,20) in test 2 -> plot=0 during hold,
//     (11,20) re-presented on release, done delayed by 3 cycles, all 6 pixels plotted once.
//  6. reset mid-sweep -> same cycle: plot=0, busy=0, send=1, x/y=0, no done.
//     A start pulsed during SWEEP in a separate run -> ignored, pixel count unchanged.

Source files
------------

// File: rtl/screen_clear_sweeper.sv
// Clear-pass pixel generator: sweeps a clipped rectangle (or the whole 160x120 frame)
// in raster order with a fixed colour and steers the downstream clear/regular mux.
module screen_clear_sweeper #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       full_screen,
    input  logic [7:0] rect_x0,
    input  logic [6:0] rect_y0,
    input  logic [7:0] rect_w,
    input  logic [6:0] rect_h,
    input  logic       hold,
    output logic [7:0] x_clear,
    output logic [6:0] y_clear,
    output logic [2:0] color_clear,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       send_clear_or_regular
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

    state_t     state_r;
    logic [7:0] x_start_r;
    logic [7:0] x_end_r;
    logic [6:0] y_end_r;

    logic [8:0] x_last_s;
    logic [8:0] y_last_s;
    logic [7:0] x_first_s;
    logic [6:0] y_first_s;
    logic [7:0] x_end_s;
    logic [6:0] y_end_s;
    logic       empty_s;

    assign color_clear = CLEAR_COLOR;

    // Clip the requested rectangle to the frame; 9-bit sums keep x0+w and y0+h from wrapping.
    always_comb begin
        x_last_s  = {1'b0, rect_x0} + {1'b0, rect_w} - 9'd1;
        y_last_s  = {2'b00, rect_y0} + {2'b00, rect_h} - 9'd1;
        x_first_s = rect_x0;
        y_first_s = rect_y0;
        x_end_s   = 8'd0;
        y_end_s   = 7'd0;
        empty_s   = 1'b0;
        if (full_screen) begin
            x_first_s = 8'd0;
            y_first_s = 7'd0;
            x_end_s   = X_MAX[7:0];
            y_end_s   = Y_MAX[6:0];
            empty_s   = 1'b0;
        end else begin
            x_end_s = (x_last_s > X_MAX) ? X_MAX[7:0] : x_last_s[7:0];
            y_end_s = (y_last_s > Y_MAX) ? Y_MAX[6:0] : y_last_s[6:0];
            empty_s = (rect_w == 8'd0) || (rect_h == 7'd0) ||
                      ({1'b0, rect_x0} > X_MAX) || ({2'b00, rect_y0} > Y_MAX);
        end
    end

    // Sweep FSM with all outputs registered; send_clear_or_regular always mirrors ~busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r               <= IDLE;
            x_start_r             <= 8'd0;
            x_end_r               <= 8'd0;
            y_end_r               <= 7'd0;
            x_clear               <= 8'd0;
            y_clear               <= 7'd0;
            plot                  <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            send_clear_or_regular <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_start_r <= x_first_s;
                        x_end_r   <= x_end_s;
                        y_end_r   <= y_end_s;
                        if (empty_s) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r               <= SWEEP;
                            x_clear               <= x_first_s;
                            y_clear               <= y_first_s;
                            plot                  <= 1'b1;
                            busy                  <= 1'b1;
                            send_clear_or_regular <= 1'b0;
                        end
                    end
                end
                SWEEP: begin
                    // A held cycle keeps the pixel pointer, so nothing is skipped on release.
                    if (hold) begin
                        plot <= 1'b0;
                    end else if ((x_clear == x_end_r) && (y_clear == y_end_r)) begin
                        state_r               <= DONE;
                        plot                  <= 1'b0;
                        busy                  <= 1'b0;
                        done                  <= 1'b1;
                        send_clear_or_regular <= 1'b1;
                    end else if (x_clear < x_end_r) begin
                        x_clear <= x_clear + 8'd1;
                        plot    <= 1'b1;
                    end else begin
                        x_clear <= x_start_r;
                        y_clear <= y_clear + 7'd1;
                        plot    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r               <= IDLE;
                    plot                  <= 1'b0;
                    busy                  <= 1'b0;
                    done                  <= 1'b0;
                    send_clear_or_regular <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_clear_sweeper.sv
// Bench for screen_clear_sweeper: table of directed sweeps, random rectangles with random
// hold and stray start pulses, checked against a raster-list model, plus reset sequences.
module tb_screen_clear_sweeper;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       full_screen;
    logic [7:0] rect_x0;
    logic [6:0] rect_y0;
    logic [7:0] rect_w;
    logic [6:0] rect_h;
    logic       hold;
    logic [7:0] x_clear;
    logic [6:0] y_clear;
    logic [2:0] color_clear;
    logic       plot;
    logic       busy;
    logic       done;
    logic       send_clear_or_regular;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];

    typedef struct {
        bit full;
        int x0;
        int y0;
        int w;
        int h;
        int exp_n;       // -1: take the count from the model
        int hold_mode;   // 0 none, 1 random, 2 three cycles on (11,20), 3 hold together with start
        bit start_noise; // pulse start and scramble the rect inputs during the sweep
    } vec_t;

    screen_clear_sweeper dut (
        .clock(clock), .reset(reset), .start(start), .full_screen(full_screen),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_w(rect_w), .rect_h(rect_h), .hold(hold),
        .x_clear(x_clear), .y_clear(y_clear), .color_clear(color_clear), .plot(plot),
        .busy(busy), .done(done), .send_clear_or_regular(send_clear_or_regular)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: the list of pixels to be written, in raster order, from the region rules.
    function automatic void build(input vec_t v);
        int xa, xb, ya, yb;
        exp_x.delete();
        exp_y.delete();
        if (v.full) begin
            xa = 0; xb = 159; ya = 0; yb = 119;
        end else begin
            if (v.w == 0 || v.h == 0 || v.x0 >= 160 || v.y0 >= 120) return;
            xa = v.x0; ya = v.y0;
            xb = (v.x0 + v.w - 1 > 159) ? 159 : v.x0 + v.w - 1;
            yb = (v.y0 + v.h - 1 > 119) ? 119 : v.y0 + v.h - 1;
        end
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
    endfunction

    task automatic run(input vec_t v, input string tag);
        int n, idx, cycle, hcount, done_cycle, plots, busy_cycles, hold_left, budget;
        int pix_err, freeze_err, send_err, idle_plot, color_err, last_x, last_y;
        bit used_hold;
        build(v);
        n = exp_x.size();
        idx = 0; hcount = 0; done_cycle = -1; plots = 0; busy_cycles = 0; hold_left = 0;
        pix_err = 0; freeze_err = 0; send_err = 0; idle_plot = 0; color_err = 0;
        last_x = -1; last_y = -1; used_hold = 1'b0;
        budget = 4 * n + 100;
        @(negedge clock);
        full_screen = v.full;
        rect_x0 = 8'(v.x0); rect_y0 = 7'(v.y0); rect_w = 8'(v.w); rect_h = 7'(v.h);
        start = 1'b1;
        hold = (v.hold_mode == 3);
        @(negedge clock);
        start = 1'b0;
        hold = 1'b0;
        cycle = 1;
        while (cycle <= budget) begin
            if (send_clear_or_regular !== ~busy) send_err++;
            if (color_clear !== 3'b000) color_err++;
            if (plot === 1'b1) begin
                plots++;
                if (busy !== 1'b1) idle_plot++;
                if (idx < n) begin
                    if (x_clear != exp_x[idx] || y_clear != exp_y[idx]) begin
                        if (pix_err == 0)
                            $display("FAIL %s_pixel%0d actual=(%0d,%0d) expected=(%0d,%0d)",
                                     tag, idx, x_clear, y_clear, exp_x[idx], exp_y[idx]);
                        pix_err++;
                    end
                end
                idx++;
                last_x = int'(x_clear);
                last_y = int'(y_clear);
            end else if (busy === 1'b1 && plots > 0) begin
                if (int'(x_clear) != last_x || int'(y_clear) != last_y) freeze_err++;
            end
            if (done === 1'b1) begin
                done_cycle = cycle;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            case (v.hold_mode)
                1: hold = ($urandom_range(3) == 0) && (hcount < n + 50);
                2: begin
                    if (!used_hold && plot === 1'b1 && x_clear == 8'd11 && y_clear == 7'd20) begin
                        used_hold = 1'b1;
                        hold_left = 3;
                    end
                    hold = (hold_left > 0);
                    if (hold_left > 0) hold_left--;
                end
                default: hold = 1'b0;
            endcase
            if (busy === 1'b1 && hold) hcount++;
            if (v.start_noise) begin
                start = ($urandom_range(3) == 0);
                full_screen = 1'($urandom);
                rect_x0 = 8'($urandom_range(159));
                rect_y0 = 7'($urandom_range(119));
                rect_w = 8'($urandom_range(255));
                rect_h = 7'($urandom_range(127));
            end
            @(negedge clock);
            cycle++;
        end
        start = 1'b0;
        hold = 1'b0;
        check({tag, "_done_cycle"}, done_cycle, n + 1 + hcount);
        check({tag, "_plot_count"}, plots, (v.exp_n >= 0) ? v.exp_n : n);
        check({tag, "_pixel_errors"}, pix_err, 0);
        check({tag, "_frozen_on_hold"}, freeze_err, 0);
        check({tag, "_busy_cycles"}, busy_cycles, n + hcount);
        check({tag, "_send_is_not_busy"}, send_err, 0);
        check({tag, "_plot_outside_busy"}, idle_plot, 0);
        check({tag, "_color"}, color_err, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_after"}, {busy, plot, send_clear_or_regular}, 3'b001);
    endtask

    vec_t tbl[11];
    vec_t rv;
    int   bad;

    initial begin
        tbl[0]  = '{1'b1, 0, 0, 0, 0, 19200, 0, 1'b0};
        tbl[1]  = '{1'b0, 10, 20, 3, 2, 6, 0, 1'b0};
        tbl[2]  = '{1'b0, 158, 118, 5, 5, 4, 0, 1'b0};
        tbl[3]  = '{1'b0, 5, 5, 0, 4, 0, 0, 1'b0};
        tbl[4]  = '{1'b0, 170, 5, 4, 4, 0, 0, 1'b0};
        tbl[5]  = '{1'b0, 10, 20, 3, 2, 6, 2, 1'b0};
        tbl[6]  = '{1'b0, 10, 20, 3, 2, 6, 0, 1'b1};
        tbl[7]  = '{1'b0, 3, 4, 1, 1, 1, 3, 1'b0};
        tbl[8]  = '{1'b0, 150, 100, 255, 127, 200, 1, 1'b0};
        tbl[9]  = '{1'b0, 5, 119, 2, 3, 2, 0, 1'b0};
        tbl[10] = '{1'b0, 5, 120, 3, 3, 0, 0, 1'b0};

        reset = 1'b1; start = 1'b0; full_screen = 1'b0; hold = 1'b0;
        rect_x0 = 8'd0; rect_y0 = 7'd0; rect_w = 8'd0; rect_h = 7'd0;
        @(negedge clock);
        @(negedge clock);
        check("reset_xy", {x_clear, y_clear}, 15'd0);
        check("reset_flags", {plot, busy, done, send_clear_or_regular}, 4'b0001);
        check("reset_color", color_clear, 3'b000);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 15; i++) begin
            rv.full = 1'b0;
            rv.x0 = $urandom_range(175);
            rv.y0 = $urandom_range(127);
            rv.w = $urandom_range(40);
            rv.h = $urandom_range(30);
            rv.exp_n = -1;
            rv.hold_mode = 1;
            rv.start_noise = 1'($urandom);
            run(rv, $sformatf("rand%0d", i));
        end

        // Reset during a sweep aborts at once and never yields a done pulse.
        @(negedge clock);
        full_screen = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("midsweep_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midsweep_reset_xy", {x_clear, y_clear}, 15'd0);
        check("midsweep_reset_flags", {plot, busy, done, send_clear_or_regular}, 4'b0001);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("after_reset_no_done", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
